alu_op_decode_seq: RTL and testbench

- Parametrised, registered ALU opcode decoder.
- Turns a handshaked opcode into a one-hot operation-enable vector for the ALU datapath.
- Also sequences multi-cycle operations (mult/div): holds the enable, asserts busy for a fixed count and signals completion.
- Sits between the control unit and the 32-bit ALU; replaces per-operation enable decoders.

---
 rtl/alu_op_decode_seq.sv | 109 ++++++++++
 tb/tb_alu_op_decode_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decode_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode_seq
//  Purpose  : Registered ALU opcode decoder with multi-cycle (mult/div) sequencing.
//  Revision : 1.0
// ============================================================================
module alu_op_decode_seq #(
    parameter int                  OP_W         = 5,
    parameter logic [2**OP_W-1:0]  LEGAL_MASK   = 'h000000FF,
    parameter logic [2**OP_W-1:0]  MULTI_MASK   = 'h000000C0,
    parameter int                  MULTI_CYCLES = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OP_W-1:0]     ctrl_ALUopcode,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2**OP_W-1:0]  en_onehot,
    output logic                out_valid,
    output logic                busy,
    output logic                illegal
);

    localparam int             N        = 2**OP_W;
    localparam int             CW       = (MULTI_CYCLES > 1) ? $clog2(MULTI_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MULTI_CYCLES - 1);
    localparam logic           MC_ONE   = (MULTI_CYCLES == 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    en_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            illegal_q;

    logic            w_accept;
    logic            w_legal;
    logic            w_multi;
    logic [N-1:0]    w_onehot;

    assign in_ready  = (state_q == IDLE);
    assign w_accept  = in_valid & in_ready;
    assign w_legal   = LEGAL_MASK[ctrl_ALUopcode];
    assign w_multi   = MULTI_MASK[ctrl_ALUopcode];
    assign w_onehot  = N'(1) << ctrl_ALUopcode;

    assign en_onehot = en_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign illegal   = illegal_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            en_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    en_q        <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    illegal_q   <= 1'b0;
                    if (w_accept) begin
                        // Illegal takes priority over the multi-cycle mask.
                        if (!w_legal) begin
                            out_valid_q <= 1'b1;
                            illegal_q   <= 1'b1;
                        end else if (w_multi) begin
                            state_q     <= BUSY;
                            cnt_q       <= CNT_LOAD;
                            en_q        <= w_onehot;
                            busy_q      <= 1'b1;
                            out_valid_q <= MC_ONE;
                        end else begin
                            en_q        <= w_onehot;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        en_q        <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end else begin
                        // Result pulse lands in the cycle where the count reaches zero.
                        cnt_q       <= cnt_q - CW'(1);
                        out_valid_q <= (cnt_q == CW'(1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decode_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_decode_seq
//  Purpose  : Self-checking bench for alu_op_decode_seq (default and 1-cycle builds).
//  Revision : 1.0
// ============================================================================
module tb_alu_op_decode_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [4:0]  op;
    logic        iv;
    logic        rdy;
    logic [31:0] en;
    logic        ov;
    logic        bsy;
    logic        ill;

    logic [4:0]  op2;
    logic        iv2;
    logic        rdy2;
    logic [31:0] en2;
    logic        ov2;
    logic        bsy2;
    logic        ill2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_op_decode_seq u_dut (
        .clock          (clk),
        .reset          (rst),
        .ctrl_ALUopcode (op),
        .in_valid       (iv),
        .in_ready       (rdy),
        .en_onehot      (en),
        .out_valid      (ov),
        .busy           (bsy),
        .illegal        (ill)
    );

    alu_op_decode_seq #(.MULTI_CYCLES(1)) u_dut1 (
        .clock          (clk),
        .reset          (rst),
        .ctrl_ALUopcode (op2),
        .in_valid       (iv2),
        .in_ready       (rdy2),
        .en_onehot      (en2),
        .out_valid      (ov2),
        .busy           (bsy2),
        .illegal        (ill2)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  op;
        logic [31:0] en;
        logic        ov;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_main(input string tag, input logic [31:0] e_en, input logic e_ov,
                              input logic e_bsy, input logic e_ill, input logic e_rdy);
        check({tag, ".en"},    en,  e_en);
        check({tag, ".ov"},    {31'd0, ov},  {31'd0, e_ov});
        check({tag, ".busy"},  {31'd0, bsy}, {31'd0, e_bsy});
        check({tag, ".ill"},   {31'd0, ill}, {31'd0, e_ill});
        check({tag, ".ready"}, {31'd0, rdy}, {31'd0, e_rdy});
    endtask

    initial begin
        op  = 5'd0; iv  = 1'b0;
        op2 = 5'd0; iv2 = 1'b0;

        // Single-cycle and illegal vectors: result appears the cycle after the edge.
        vecs.push_back('{1'b1, 5'd2,  32'h0000_0004, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd0,  32'h0000_0001, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd3,  32'h0000_0008, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd3,  32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd9,  32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 5'd9,  32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd5,  32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd5,  32'h0000_0020, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd31, 32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 5'd4,  32'h0000_0010, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd8,  32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 5'd1,  32'h0000_0002, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0});

        // Reset held two cycles, then idle.
        #1;
        check_main("rst_async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_main("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_main("idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            iv = vecs[i].iv;
            op = vecs[i].op;
            @(posedge clk);
            #1;
            check_main($sformatf("vec%0d", i), vecs[i].en, vecs[i].ov, 1'b0, vecs[i].ill, 1'b1);
        end

        // Multi-cycle op 6, with op 2 held valid the whole time.
        @(negedge clk);
        iv = 1'b1;
        op = 5'd6;
        @(posedge clk);
        for (int k = 1; k <= 32; k++) begin
            #1;
            check_main($sformatf("mul_c%0d", k), 32'h0000_0040, (k == 32), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            op = 5'd2;
            @(posedge clk);
        end
        #1;
        check_main("mul_done", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_main("mul_next", 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        iv = 1'b0;
        @(posedge clk);
        #1;
        check_main("mul_quiet", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Div op 7 aborted by an asynchronous reset between edges.
        @(negedge clk);
        iv = 1'b1;
        op = 5'd7;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_main("div_c10", 32'h0000_0080, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_main("div_abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (ov !== 1'b0 || rdy !== 1'b1 || bsy !== 1'b0) begin
                check_main($sformatf("post_abort%0d", k), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        check_main("post_abort_end", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // MULTI_CYCLES=1 build: busy and out_valid together for one cycle.
        @(negedge clk);
        iv2 = 1'b1;
        op2 = 5'd6;
        @(posedge clk);
        #1;
        check("mc1.busy",  {31'd0, bsy2}, 32'd1);
        check("mc1.ov",    {31'd0, ov2},  32'd1);
        check("mc1.en",    en2, 32'h0000_0040);
        check("mc1.ready", {31'd0, rdy2}, 32'd0);
        @(posedge clk);
        #1;
        check("mc1_idle.busy",  {31'd0, bsy2}, 32'd0);
        check("mc1_idle.ov",    {31'd0, ov2},  32'd0);
        check("mc1_idle.en",    en2, 32'h0);
        check("mc1_idle.ready", {31'd0, rdy2}, 32'd1);
        @(posedge clk);
        #1;
        check("mc1_again.busy", {31'd0, bsy2}, 32'd1);
        check("mc1_again.ov",   {31'd0, ov2},  32'd1);
        @(negedge clk);
        iv2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mc1_end.busy", {31'd0, bsy2}, 32'd0);
        check("mc1_end.ill",  {31'd0, ill2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
